instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word read per cycle while there is room, and buffers the
// returning words with their PCs in a small circular queue that the decode stage drains.
module instr_fetch_queue #(
  parameter int MEM_ADDR_W = 10,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fetch_en,
  input  logic [31:0]           i_pc,
  output logic                  o_pc_adv,
  output logic [31:0]           o_pc_next,
  output logic                  o_imem_en,
  output logic [MEM_ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]           i_imem_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_instr,
  output logic [31:0]           o_instr_pc,
  output logic [31:0]           o_instr_pc4
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic [31:0]      tag;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic           pop;
  logic           push;
  logic           issue;
  logic [CNT_W:0] occupancy;

  assign pop  = o_valid & i_ready;
  assign push = inflight & ~i_flush;

  // Entries already queued plus the one still in memory, less the one leaving this edge.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);

  // NOTE: rst gates the combinational strobe so no fetch can be signalled while reset is held,
  // even though the registers themselves are already cleared.
  assign issue = rst & i_fetch_en & ~i_flush & (occupancy < DEPTH_V);

  assign o_imem_en   = issue;
  assign o_pc_adv    = issue;
  assign o_pc_next   = i_pc + 32'd4;
  assign o_imem_addr = i_pc[MEM_ADDR_W+1:2];

  assign o_valid     = (count != '0);
  assign o_instr     = instr_mem[head];
  assign o_instr_pc  = pc_mem[head];
  assign o_instr_pc4 = pc_mem[head] + 32'd4;

  // NOTE: all control state uses non-blocking assignments so every register sees the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      tag      <= '0;
    end else if (i_flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      inflight <= issue;
      if (issue) tag <= i_pc;
    end
  end

  // NOTE: queue storage is deliberately not reset; o_valid (count) alone decides whether the
  // head entry means anything, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= i_imem_data;
      pc_mem[tail]    <= tag;
    end
  end

endmodule
